spi_flash_read_seq: RTL

- Command sequencer directly upstream/downstream of the single-lane SPI flash master.
- On a start request it pushes a standard READ (0x03) command, a 24-bit address and LEN dummy bytes into the master's TX FIFO.
- It pops the master's RX FIFO, discards the 4 header echo bytes, and streams the LEN payload bytes to the consumer.
- It throttles pushes so the master's 8-deep FIFOs never overflow.

---
 rtl/spi_flash_read_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/spi_flash_read_seq.sv
// READ (0x03) command sequencer for the single-lane SPI flash master.
// It pushes the command, address and dummy bytes, then streams the payload back from the RX FIFO.
module spi_flash_read_seq #(
    parameter int          ADDR_WIDTH      = 24,
    parameter int          LEN_WIDTH       = 16,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [7:0]  CMD_READ        = 8'h03,
    parameter int          CS_INDEX        = 0
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  startIn,
    input  logic [ADDR_WIDTH-1:0] addrIn,
    input  logic [LEN_WIDTH-1:0]  lenIn,
    output logic                  busyOut,
    output logic                  doneOut,
    output logic [7:0]            dataOut,
    output logic                  dataValidOut,
    output logic [7:0]            spiTxDataOut,
    output logic                  spiTxEnOut,
    output logic [31:0]           spiCsOut,
    input  logic [7:0]            spiRxDataIn,
    input  logic                  spiRxRdyIn,
    output logic                  spiRxRdEnOut
);

    localparam int CW = LEN_WIDTH + 1;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         total_q, total_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_en_q, tx_en_d;

    logic [CW-1:0] outstanding;
    logic          push;
    logic          pop;

    assign outstanding = tx_cnt_q - rx_cnt_q;
    assign pop  = spiRxRdyIn && busy_q && (rx_cnt_q < total_q);
    // Throttle uses this cycle's counters, so a same-cycle pop does not free a slot until next cycle.
    assign push = ((state_q == S_CMD) || (state_q == S_DATA)) && (tx_cnt_q < total_q)
                  && (outstanding < CW'(MAX_OUTSTANDING));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        total_d   = total_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        data_d    = data_q;
        valid_d   = 1'b0;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;

        if (pop) begin
            rx_cnt_d = rx_cnt_q + CW'(1);
            if (rx_cnt_q >= CW'(4)) begin
                data_d  = spiRxDataIn;
                valid_d = 1'b1;
            end
        end

        if (push) begin
            tx_en_d  = 1'b1;
            tx_cnt_d = tx_cnt_q + CW'(1);
            if (tx_cnt_q == CW'(0))      tx_data_d = CMD_READ;
            else if (tx_cnt_q == CW'(1)) tx_data_d = addr_q[23:16];
            else if (tx_cnt_q == CW'(2)) tx_data_d = addr_q[15:8];
            else if (tx_cnt_q == CW'(3)) tx_data_d = addr_q[7:0];
            else                         tx_data_d = 8'h00;
        end

        case (state_q)
            S_IDLE: begin
                if (startIn) begin
                    if (lenIn != '0) begin
                        addr_d   = addrIn;
                        total_d  = {1'b0, lenIn} + CW'(4);
                        tx_cnt_d = '0;
                        rx_cnt_d = '0;
                        busy_d   = 1'b1;
                        state_d  = S_CMD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_CMD: begin
                if (tx_cnt_d == CW'(4)) state_d = S_DATA;
            end
            S_DATA: begin
                if (tx_cnt_d == total_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (rx_cnt_q == total_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            total_q   <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            total_q   <= total_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
        end
    end

    assign busyOut      = busy_q;
    assign doneOut      = done_q;
    assign dataOut      = data_q;
    assign dataValidOut = valid_q;
    assign spiTxDataOut = tx_data_q;
    assign spiTxEnOut   = tx_en_q;
    assign spiRxRdEnOut = pop;
    assign spiCsOut     = 32'(CS_INDEX);

endmodule
